// File: rtl/fpga_cfg_pkg.sv
// Shared constants for the eFPGA configuration block: default chain sizes and mprj pad indices.
// Pure definitions, no logic, latency or flow control.
package fpga_cfg_pkg;

    localparam int CHAIN_LEN_DEF = 29696;
    localparam int SCAN_LEN_DEF  = 64;

    // Harness pad assignment for the fabric control/config signals
    localparam int PIN_TEST_EN   = 0;
    localparam int PIN_IO_ISOL_N = 1;
    localparam int PIN_RESET     = 2;
    localparam int PIN_PRESET    = 3;
    localparam int PIN_SC_TAIL   = 11;
    localparam int PIN_CCFF_HEAD = 12;
    localparam int PIN_LA_SEL    = 25;
    localparam int PIN_SC_HEAD   = 26;
    localparam int PIN_CCFF_TAIL = 35;
    localparam int PIN_OP_CLK    = 36;
    localparam int PIN_PROG_CLK  = 37;

endpackage

// File: rtl/fpga_shift_chain.sv
// Serial-in/parallel-out shift register with enable; bit 0 is nearest din_i.
// One cycle per stage, dout_o is the last stage straight from its flop; holds when en_i is low, no backpressure.
module fpga_shift_chain #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             din_i,
    output logic [WIDTH-1:0] q_o,
    output logic             dout_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH > 1) begin : g_multi
            assign shifted = {data_q[WIDTH-2:0], din_i};
        end else begin : g_single
            assign shifted = din_i;
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o    = data_q;
    assign dout_o = data_q[WIDTH-1];

endmodule

// File: rtl/fpga_ccff_chain.sv
// eFPGA configuration chain: CHAIN_LEN-bit bitstream shift, saturating load counter, optional scan chain (FPGA_SCAN_CHAIN_EN).
// Head-to-tail latency CHAIN_LEN edges; shifts every prog_clk edge with no stall or backpressure.
module fpga_ccff_chain
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int SCAN_LEN  = SCAN_LEN_DEF
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 ccff_head,
    output logic                 ccff_tail,
    input  logic                 test_en,
    input  logic                 sc_head,
    output logic                 sc_tail,
    input  logic                 io_isol_n,
    output logic [CHAIN_LEN-1:0] cfg_q,
    output logic                 cfg_done,
    output logic                 cfg_valid,
    output logic [1:0]           tail_oeb
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

    logic [CNT_W-1:0] shift_cnt_q;
    logic [CNT_W-1:0] shift_cnt_d;

    fpga_shift_chain #(
        .WIDTH (CHAIN_LEN)
    ) u_cfg_chain (
        .clk_i  (prog_clk),
        .rst_ni (pReset),
        .en_i   (1'b1),
        .din_i  (ccff_head),
        .q_o    (cfg_q),
        .dout_o (ccff_tail)
    );

    // Counter saturates so cfg_done stays up while the chain keeps streaming
    always_comb begin
        shift_cnt_d = shift_cnt_q;
        if (shift_cnt_q != CNT_FULL) begin
            shift_cnt_d = shift_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            shift_cnt_q <= '0;
        end else begin
            shift_cnt_q <= shift_cnt_d;
        end
    end

    assign cfg_done  = (shift_cnt_q == CNT_FULL);
    assign cfg_valid = cfg_done & io_isol_n;
    assign tail_oeb  = 2'b00;

`ifdef FPGA_SCAN_CHAIN_EN
    logic [SCAN_LEN-1:0] scan_q_unused;

    fpga_shift_chain #(
        .WIDTH (SCAN_LEN)
    ) u_scan_chain (
        .clk_i  (prog_clk),
        .rst_ni (pReset),
        .en_i   (test_en),
        .din_i  (sc_head),
        .q_o    (scan_q_unused),
        .dout_o (sc_tail)
    );
`else
    logic unused_scan_in;
    assign unused_scan_in = test_en ^ sc_head;
    assign sc_tail        = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_ccff_chain.sv
// Scoreboard bench for fpga_ccff_chain with a 16-stage chain: expected tail bits queued as head bits are driven.
module tb_fpga_ccff_chain;

    localparam int L = 16;
    localparam int S = 64;

    logic         prog_clk = 1'b0;
    logic         clk_en   = 1'b0;
    logic         pReset;
    logic         ccff_head;
    logic         ccff_tail;
    logic         test_en;
    logic         sc_head;
    logic         sc_tail;
    logic         io_isol_n;
    logic [L-1:0] cfg_q;
    logic         cfg_done;
    logic         cfg_valid;
    logic [1:0]   tail_oeb;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    bit tail_sb[$];
    bit scan_sb[$];
    bit sc_exp  = 1'b0;

    fpga_ccff_chain #(
        .CHAIN_LEN (L),
        .SCAN_LEN  (S)
    ) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .ccff_head (ccff_head),
        .ccff_tail (ccff_tail),
        .test_en   (test_en),
        .sc_head   (sc_head),
        .sc_tail   (sc_tail),
        .io_isol_n (io_isol_n),
        .cfg_q     (cfg_q),
        .cfg_done  (cfg_done),
        .cfg_valid (cfg_valid),
        .tail_oeb  (tail_oeb)
    );

    // Clock parks low whenever clk_en is dropped
    always #5 prog_clk = clk_en ? ~prog_clk : 1'b0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hung run, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sb_clear();
        tail_sb.delete();
        scan_sb.delete();
        for (int i = 0; i < L - 1; i++) tail_sb.push_back(1'b0);
        for (int i = 0; i < S - 1; i++) scan_sb.push_back(1'b0);
        sc_exp  = 1'b0;
        exp_cnt = 0;
    endtask

    // Reset sequence with the clock held low around the release
    task automatic do_reset();
        clk_en = 1'b0;
        #20;
        pReset = 1'b0;
        #10;
        pReset = 1'b1;
        #10;
        sb_clear();
        clk_en = 1'b1;
    endtask

    // One shift: drive while low, push expectation, clock, check on the falling edge
    task automatic step(input bit h, input bit sh);
        bit exp_tail;
        ccff_head = h;
        sc_head   = sh;
        tail_sb.push_back(h);
        if (test_en) scan_sb.push_back(sh);
        @(posedge prog_clk);
        @(negedge prog_clk);
        exp_tail = tail_sb.pop_front();
        if (exp_cnt < L) exp_cnt++;
        chk("ccff_tail", ccff_tail, exp_tail);
        chk("cfg_done", cfg_done, exp_cnt == L);
        chk("cfg_valid", cfg_valid, (exp_cnt == L) && io_isol_n);
`ifdef FPGA_SCAN_CHAIN_EN
        if (test_en) sc_exp = scan_sb.pop_front();
        chk("sc_tail", sc_tail, sc_exp);
`else
        chk("sc_tail_tied", sc_tail, 1'b0);
`endif
    endtask

    initial begin
        logic [L-1:0] pat;
        pat       = 16'hA5C3;
        pReset    = 1'b0;
        ccff_head = 1'b1;
        test_en   = 1'b0;
        sc_head   = 1'b0;
        io_isol_n = 1'b1;
        clk_en    = 1'b1;

        // Reset hold with head driven high
        repeat (10) @(negedge prog_clk);
        chk("rst_tail", ccff_tail, 1'b0);
        chk("rst_cfg_q", cfg_q, '0);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_sc_tail", sc_tail, 1'b0);
        chk("tail_oeb", tail_oeb, 2'b00);
        do_reset();

        // Single pulse
        step(1'b1, 1'b0);
        repeat (L + 2) step(1'b0, 1'b0);
        chk("pulse_done", cfg_done, 1'b1);

        // Pattern load, MSB first
        do_reset();
        for (int i = L - 1; i >= 0; i--) step(pat[i], 1'b0);
        chk("pattern_cfg_q", cfg_q, 16'hA5C3);

        // Isolation gating
        io_isol_n = 1'b0;
        #1;
        chk("isol_valid_lo", cfg_valid, 1'b0);
        io_isol_n = 1'b1;
        #1;
        chk("isol_valid_hi", cfg_valid, 1'b1);

        // Random stream past saturation, then async reset mid-stream
        do_reset();
        for (int i = 0; i < 100; i++) step(1'($urandom_range(1)), 1'b0);
        chk("stream_cfg_q_nz", (cfg_q != '0), 1'b1);
        pReset = 1'b0;
        #1;
        chk("mid_rst_cfg_q", cfg_q, '0);
        chk("mid_rst_tail", ccff_tail, 1'b0);
        chk("mid_rst_done", cfg_done, 1'b0);
        do_reset();
        step(1'b1, 1'b0);
        repeat (L + 2) step(1'b0, 1'b0);

        // Scan chain: pulse through, then freeze with test_en low
        do_reset();
        test_en = 1'b1;
        step(1'b0, 1'b1);
        repeat (S + 1) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (S - 2) step(1'b0, 1'b0);
        test_en = 1'b0;
        repeat (8) step(1'b0, 1'b1);
`ifdef FPGA_SCAN_CHAIN_EN
        test_en = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        test_en = 1'b0;
`endif
        chk("final_tail_oeb", tail_oeb, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
